acc_display_ctl: RTL and testbench

//  Parametrised debug readout for the TIS core array. Shows one of NCH signed

---
 rtl/tis_disp_pkg.sv | 33 +++
 rtl/bin2bcd_seq.sv | 51 +++++
 rtl/acc_display_ctl.sv | 122 ++++++++++++
 tb/tb_acc_display_ctl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/tis_disp_pkg.sv
// Shared types and 7-segment glyphs for the accumulator debug readout.
// Glyphs are active-low, bit6=g .. bit0=a.
package tis_disp_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} disp_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift iteration per clock, W clocks per conversion.
// o_done marks the final iteration, so o_bcd is valid in the cycle after o_done.
module bin2bcd_seq #(
  parameter int W    = 11,
  parameter int NDIG = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [W-1:0]      i_mag,
  output logic              o_busy,
  output logic              o_done,
  output logic [4*NDIG-1:0] o_bcd
);

  localparam int CW = $clog2(W + 1);

  logic [4*NDIG+W-1:0] r_sr;
  logic [CW-1:0]       r_cnt;
  logic                r_busy;
  logic [4*NDIG-1:0]   w_adj;

  genvar gi;
  generate
    for (gi = 0; gi < NDIG; gi++) begin : g_adj
      assign w_adj[4*gi +: 4] = (r_sr[W+4*gi +: 4] >= 4'd5) ? r_sr[W+4*gi +: 4] + 4'd3
                                                            : r_sr[W+4*gi +: 4];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr   <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (r_busy) begin
      r_sr  <= {w_adj[4*NDIG-2:0], r_sr[W-1:0], 1'b0};
      r_cnt <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) r_busy <= 1'b0;
    end else if (i_start) begin
      r_sr   <= {{(4*NDIG){1'b0}}, i_mag};
      r_cnt  <= CW'(W);
      r_busy <= 1'b1;
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_busy && (r_cnt == CW'(1));
  assign o_bcd  = r_sr[4*NDIG+W-1:W];

endmodule

// File: rtl/acc_display_ctl.sv
// Debug readout: shows one of NCH signed accumulators on HEX5..HEX0 in signed decimal or raw hex.
// Channel select, snapshot capture, layout and leading-zero blanking live here; BCD conversion is delegated.
module acc_display_ctl
  import tis_disp_pkg::*;
#(
  parameter int  NCH  = 4,
  parameter int  W    = 11,
  parameter int  NDIG = 4,
  localparam int SW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH*W-1:0] acc,
  input  logic             step_next,
  input  logic             step_prev,
  input  logic             hex_mode,
  input  logic             freeze,
  output logic [6*7-1:0]   hex_seg,
  output logic [SW-1:0]    sel,
  output logic             disp_valid
);

  generate
    if (10**NDIG <= 2**(W-1)) begin : g_bad_ndig
      $error("acc_display_ctl: NDIG too small for accumulator width W");
    end
  endgenerate

  disp_state_t       r_state;
  logic [SW-1:0]     r_sel;
  logic [W-1:0]      r_snap;
  logic [3:0]        r_snap_ch;
  logic              r_snap_mode;
  logic [41:0]       r_hex_seg;
  logic              r_disp_valid;

  logic [W-1:0]      w_acc_sel;
  logic [W-1:0]      w_mag;
  logic              w_start;
  logic              w_busy;
  logic              w_done;
  logic [4*NDIG-1:0] w_bcd;
  logic [15:0]       w_snap16;
  logic [41:0]       w_disp_next;

  assign w_acc_sel = acc[r_sel*W +: W];
  // Most negative value maps to 2**(W-1), which still fits as W-bit unsigned.
  assign w_mag     = w_acc_sel[W-1] ? (~w_acc_sel + W'(1)) : w_acc_sel;
  assign w_start   = (r_state == IDLE) && !freeze && !w_busy;
  assign w_snap16  = 16'($signed(r_snap));

  bin2bcd_seq #(.W(W), .NDIG(NDIG)) u_bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_start),
    .i_mag   (w_mag),
    .o_busy  (w_busy),
    .o_done  (w_done),
    .o_bcd   (w_bcd)
  );

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dig
      logic [6:0] w_dec;
      if (gi < NDIG) begin : g_bcd
        // Units digit is always lit; higher digits only when a nonzero digit sits at or above them.
        logic w_lit;
        assign w_lit = (gi == 0) || (|w_bcd[4*NDIG-1:4*gi]);
        assign w_dec = w_lit ? seg7(w_bcd[4*gi +: 4]) : SEG_BLANK;
      end else begin : g_none
        assign w_dec = SEG_BLANK;
      end
      assign w_disp_next[7*gi +: 7] = r_snap_mode ? seg7(w_snap16[4*gi +: 4]) : w_dec;
    end
  endgenerate

  assign w_disp_next[34:28] = (!r_snap_mode && r_snap[W-1]) ? SEG_MINUS : SEG_BLANK;
  assign w_disp_next[41:35] = seg7(r_snap_ch);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel <= '0;
    end else if (step_next && !step_prev) begin
      r_sel <= (r_sel == SW'(NCH-1)) ? '0 : r_sel + SW'(1);
    end else if (step_prev && !step_next) begin
      r_sel <= (r_sel == '0) ? SW'(NCH-1) : r_sel - SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_snap       <= '0;
      r_snap_ch    <= '0;
      r_snap_mode  <= 1'b0;
      r_hex_seg    <= {6{SEG_BLANK}};
      r_disp_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_start) begin
          r_snap      <= w_acc_sel;
          r_snap_ch   <= 4'(r_sel);
          r_snap_mode <= hex_mode;
          r_state     <= SHIFT;
        end
        SHIFT: if (w_done) r_state <= DONE;
        DONE: begin
          r_hex_seg    <= w_disp_next;
          r_disp_valid <= 1'b1;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign hex_seg    = r_hex_seg;
  assign sel        = r_sel;
  assign disp_valid = r_disp_valid;

endmodule

// File: tb/tb_acc_display_ctl.sv
// Directed bench for acc_display_ctl (NCH=4, W=11, NDIG=4); frames are written out by hand as glyph tuples.
module tb_acc_display_ctl;

  localparam logic [6:0] G0 = 7'h40, G1 = 7'h79, G2 = 7'h24, G3 = 7'h30, G4 = 7'h19;
  localparam logic [6:0] G5 = 7'h12, G7 = 7'h78, GB = 7'h03, GC = 7'h46, GF = 7'h0E;
  localparam logic [6:0] BL = 7'h7F, MI = 7'h3F;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] a [4];
  logic [43:0] acc;
  logic        step_next = 1'b0, step_prev = 1'b0, hex_mode = 1'b0, freeze = 1'b0;
  logic [41:0] hex_seg;
  logic [1:0]  sel;
  logic        disp_valid;

  int n_checks = 0;
  int n_err    = 0;

  assign acc = {a[3], a[2], a[1], a[0]};

  always #5 clk = ~clk;

  acc_display_ctl #(.NCH(4), .W(11), .NDIG(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .acc        (acc),
    .step_next  (step_next),
    .step_prev  (step_prev),
    .hex_mode   (hex_mode),
    .freeze     (freeze),
    .hex_seg    (hex_seg),
    .sel        (sel),
    .disp_valid (disp_valid)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  function automatic logic [41:0] frame(input logic [6:0] h5, h4, h3, h2, h1, h0);
    return {h5, h4, h3, h2, h1, h0};
  endfunction

  task automatic pulse(input logic n, input logic p);
    @(negedge clk);
    step_next = n;
    step_prev = p;
    @(negedge clk);
    step_next = 1'b0;
    step_prev = 1'b0;
  endtask

  task automatic settle();
    repeat (30) @(posedge clk);
    @(negedge clk);
  endtask

  // Park the FSM in IDLE, then release freeze so the next posedge is a known capture edge.
  task automatic sync_capture();
    @(negedge clk);
    freeze = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    freeze = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [41:0] hold;
    a[0] = 11'd123;
    a[1] = 11'h7FF;
    a[2] = 11'h400;
    a[3] = 11'd5;

    // Reset values, then exact first-frame latency
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_seg", hex_seg, {6{BL}});
    check("rst_sel", sel, 2'd0);
    check("rst_valid", disp_valid, 1'b0);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("valid_at_12", disp_valid, 1'b0);
    check("seg_at_12", hex_seg, {6{BL}});
    @(posedge clk);
    @(negedge clk);
    check("valid_at_13", disp_valid, 1'b1);
    check("dec_123", hex_seg, frame(G0, BL, BL, G1, G2, G3));

    // Most negative value and zero on channel 2
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    check("sel_2", sel, 2'd2);
    settle();
    check("dec_m1024", hex_seg, frame(G2, MI, G1, G0, G2, G4));
    a[2] = 11'd0;
    settle();
    check("dec_zero", hex_seg, frame(G2, BL, BL, BL, BL, G0));

    // Select wrap in both directions and simultaneous pulses
    pulse(1'b1, 1'b0);
    check("sel_3", sel, 2'd3);
    pulse(1'b1, 1'b0);
    check("sel_wrap_up", sel, 2'd0);
    pulse(1'b0, 1'b1);
    check("sel_wrap_down", sel, 2'd3);
    pulse(1'b1, 1'b1);
    check("sel_both", sel, 2'd3);

    // step_next during SHIFT: frame in flight keeps ch3, the following one shows ch0
    sync_capture();
    repeat (3) @(posedge clk);
    @(negedge clk);
    step_next = 1'b1;
    @(negedge clk);
    step_next = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("inflight_ch3", hex_seg, frame(G3, BL, BL, BL, BL, G5));
    check("sel_after_inflight", sel, 2'd0);
    repeat (13) @(posedge clk);
    @(negedge clk);
    check("next_frame_ch0", hex_seg, frame(G0, BL, BL, G1, G2, G3));

    // Raw hex mode on channel 1
    pulse(1'b1, 1'b0);
    check("sel_1", sel, 2'd1);
    hex_mode = 1'b1;
    settle();
    check("hex_m1", hex_seg, frame(G1, BL, GF, GF, GF, GF));
    a[1] = 11'h07B;
    settle();
    check("hex_07b", hex_seg, frame(G1, BL, G0, G0, G7, GB));
    a[1] = 11'h400;
    settle();
    check("hex_m1024", hex_seg, frame(G1, BL, GF, GC, G0, G0));

    // Freeze holds the display while acc changes
    hex_mode = 1'b0;
    a[1] = 11'h7FF;
    settle();
    check("dec_m1", hex_seg, frame(G1, MI, BL, BL, BL, G1));
    @(negedge clk);
    freeze = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    hold = hex_seg;
    a[1] = 11'h07B;
    for (int i = 0; i < 10; i++) begin
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("frozen", hex_seg, frame(G1, MI, BL, BL, BL, G1));
    end
    freeze = 1'b0;
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      if (hex_seg != hold) break;
    end
    check("unfrozen", hex_seg, frame(G1, BL, BL, G1, G2, G3));

    // Asynchronous reset in the middle of a conversion
    sync_capture();
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_seg", hex_seg, {6{BL}});
    check("arst_valid", disp_valid, 1'b0);
    check("arst_sel", sel, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
